sys_ctrl_gen: RTL and testbench
===============================

Name: sys_ctrl_gen

Overview:
Parametrised command controller sitting between UART RX/TX, the register file, the ALU and its clock gate. It decodes framed commands from the UART: RF write, RF read, ALU with operands, and ALU without operands. It returns RF read data and multi-byte ALU results to the TX FIFO. Compared with the current controller, it latches addresses, data and results, serialises any result width LSB-first, and adds command-timeout and error reporting.

Parameters:
DATA_WIDTH, 8, width of UART bytes, RF data and each TX word
ADDR_WIDTH, 4, RF address width
FUN_WIDTH, 4, ALU function code width
RES_WORDS, 2, ALU result width in DATA_WIDTH words (ALU_OUT width = DATA_WIDTH*RES_WORDS)
OPA_ADDR, 0, RF address written with operand A
OPB_ADDR, 1, RF address written with operand B
TIMEOUT_CYCLES, 1023, idle-wait limit per step; 0 disables timeout

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
UART_RX_DATA  in  DATA_WIDTH  received byte
UART_RX_VLD  in  1  one-cycle strobe, byte valid
FIFO_FULL  in  1  TX FIFO full
RF_RdData  in  DATA_WIDTH  RF read data
RF_RdData_Valid  in  1  read data valid strobe
ALU_OUT  in  DATA_WIDTH*RES_WORDS  ALU result
ALU_OUT_VLD  in  1  result valid strobe
RF_Address  out  ADDR_WIDTH  RF address
RF_WrEn  out  1  RF write strobe
RF_RdEn  out  1  RF read strobe
RF_WrData  out  DATA_WIDTH  RF write data
ALU_FUN  out  FUN_WIDTH  ALU function
ALU_EN  out  1  ALU enable strobe
CLKG_EN  out  1  ALU clock-gate enable
CLKDIV_EN  out  1  clock divider enable
UART_TX_DATA  out  DATA_WIDTH  TX word
UART_TX_VLD  out  1  TX push strobe
CMD_ERR  out  1  one-cycle pulse on bad command or timeout
BUSY  out  1  high whenever state != IDLE

Behaviour:
- Reset: asynchronous, active-low on RST. State=IDLE, counters cleared. All outputs 0 except CLKDIV_EN=1. CLKDIV_EN stays 1 at all times.
- All outputs are registered. Each strobe lasts exactly one cycle and appears the cycle after its triggering event.
- IDLE, on RX_VLD:
  - 0xAA -> WR_ADDR
  - 0xBB -> RD_ADDR
  - 0xCC -> OP_A
  - 0xDD -> ALU_FN
  - any other byte -> CMD_ERR pulse, stay IDLE
- Command codes compare the low 8 bits. Upper bits must be 0 when DATA_WIDTH>8.
- WR_ADDR: RX byte -> latch addr = byte[ADDR_WIDTH-1:0] -> WR_DATA.
- WR_DATA: RX byte -> RF_WrEn=1, RF_Address=latched addr, RF_WrData=byte -> IDLE. Address is held stable for the whole strobe.
- RD_ADDR: RX byte -> RF_RdEn=1 with RF_Address=byte[ADDR_WIDTH-1:0] -> RD_WAIT.
- RD_WAIT: RF_RdData_Valid -> latch RF_RdData into TX buffer, words=1 -> TX.
- OP_A: RX byte -> RF write to OPA_ADDR -> OP_B.
- OP_B: RX byte -> RF write to OPB_ADDR -> ALU_FN.
- ALU_FN:
  - CLKG_EN=1 from the cycle after entry.
  - RX byte -> ALU_FUN=byte[FUN_WIDTH-1:0], ALU_EN=1 -> ALU_WAIT.
  - ALU_FUN holds its value until the next ALU command.
- ALU_WAIT:
  - CLKG_EN stays 1.
  - ALU_OUT_VLD -> latch full ALU_OUT, words=RES_WORDS -> TX.
  - CLKG_EN drops to 0 the cycle after the latch.
- TX:
  - While FIFO_FULL=1, stall with no push and no timeout.
  - When FIFO_FULL=0: UART_TX_VLD=1, UART_TX_DATA = current word, LSB word first.
  - One push per cycle at most. Word index increments on each push.
  - After the last word -> IDLE.
  - FIFO_FULL is sampled every cycle, so back-to-back pushes are allowed.
- UART_RX_VLD is ignored in RD_WAIT, ALU_WAIT and TX (the byte is dropped with no error).
- Timeout:
  - A cycle counter clears on state entry and counts in WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FN and ALU_WAIT.
  - On reaching TIMEOUT_CYCLES: CMD_ERR pulse, go to IDLE, CLKG_EN=0, no RF/ALU strobe issued.
  - If a valid event and the timeout coincide, the valid event wins.
- Reset mid-operation: aborts immediately. Pending TX words are discarded and no strobe is emitted.
- Latency: a command byte accepted at cycle N produces its RF/ALU strobe at N+1. The first TX push happens one cycle after the data is latched, provided FIFO not full.

Test Plan:
- Write: RX AA,05,3C -> one-cycle RF_WrEn with RF_Address=5, RF_WrData=0x3C; BUSY low after; no CMD_ERR.
- Read with backpressure: RX BB,07; RF returns 0x5A; FIFO_FULL=1 for 10 cycles -> RF_RdEn with addr 7, no push for 10 cycles, then one push of 0x5A.
- ALU with operands: RX CC,12,34,DD-sequence function byte 01 -> RF writes 0x12@0 and 0x34@1; ALU_EN with ALU_FUN=1; ALU_OUT=0x0446 -> pushes 0x46 then 0x04; CLKG_EN high between function byte and result latch.
- RES_WORDS=3 build, DD then 02, ALU_OUT=0xABCDEF -> pushes EF,CD,AB on consecutive cycles with FIFO not full.
- Errors: RX 0x77 in IDLE -> CMD_ERR pulse, state IDLE. AA then silence for TIMEOUT_CYCLES -> CMD_ERR, IDLE, no RF_WrEn.
- Reset mid-TX: assert RST between the two ALU result pushes -> outputs return to reset values (CLKDIV_EN=1); second word is never pushed.

Source files
------------

// File: rtl/sys_ctrl_gen.sv
// Command controller between the UART, register file and ALU.
// Decodes framed commands, drives RF/ALU strobes and serialises results LSB word first.
module sys_ctrl_gen #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int FUN_WIDTH      = 4,
   parameter int RES_WORDS      = 2,
   parameter int OPA_ADDR       = 0,
   parameter int OPB_ADDR       = 1,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic [DATA_WIDTH-1:0]           UART_RX_DATA,
   input  logic                            UART_RX_VLD,
   input  logic                            FIFO_FULL,
   input  logic [DATA_WIDTH-1:0]           RF_RdData,
   input  logic                            RF_RdData_Valid,
   input  logic [DATA_WIDTH*RES_WORDS-1:0] ALU_OUT,
   input  logic                            ALU_OUT_VLD,
   output logic [ADDR_WIDTH-1:0]           RF_Address,
   output logic                            RF_WrEn,
   output logic                            RF_RdEn,
   output logic [DATA_WIDTH-1:0]           RF_WrData,
   output logic [FUN_WIDTH-1:0]            ALU_FUN,
   output logic                            ALU_EN,
   output logic                            CLKG_EN,
   output logic                            CLKDIV_EN,
   output logic [DATA_WIDTH-1:0]           UART_TX_DATA,
   output logic                            UART_TX_VLD,
   output logic                            CMD_ERR,
   output logic                            BUSY
);

   localparam int RES_W = DATA_WIDTH * RES_WORDS;
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int REM_W = (RES_WORDS > 1) ? $clog2(RES_WORDS + 1) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
      S_OP_A, S_OP_B, S_ALU_FN, S_ALU_WAIT, S_TX
   } state_t;

   state_t                  state_r;
   logic [CNT_W-1:0]        cnt_r;
   logic [REM_W-1:0]        rem_r;
   logic [RES_W-1:0]        tx_buf_r;
   logic [ADDR_WIDTH-1:0]   addr_r;
   logic [ADDR_WIDTH-1:0]   rf_addr_r;
   logic [DATA_WIDTH-1:0]   rf_wdata_r;
   logic [FUN_WIDTH-1:0]    alu_fun_r;
   logic [DATA_WIDTH-1:0]   tx_data_r;
   logic                    rf_wr_en_r, rf_rd_en_r, alu_en_r, clkg_en_r, clkdiv_en_r;
   logic                    tx_vld_r, cmd_err_r, busy_r;
   logic                    evt_s, counted_s, tmo_s;

   // Per-state progress event and whether the state is subject to the idle timeout
   always_comb begin
      evt_s     = 1'b0;
      counted_s = 1'b1;
      case (state_r)
         S_IDLE, S_TX: begin
            evt_s     = 1'b0;
            counted_s = 1'b0;
         end
         S_RD_WAIT:  evt_s = RF_RdData_Valid;
         S_ALU_WAIT: evt_s = ALU_OUT_VLD;
         default:    evt_s = UART_RX_VLD;
      endcase
   end

   // A coinciding progress event always beats the timeout
   assign tmo_s = (TIMEOUT_CYCLES != 0) && counted_s && !evt_s && (cnt_r == TMO_LAST);

   // Controller state machine with registered outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r     <= S_IDLE;
         cnt_r       <= '0;
         rem_r       <= '0;
         tx_buf_r    <= '0;
         addr_r      <= '0;
         rf_addr_r   <= '0;
         rf_wdata_r  <= '0;
         alu_fun_r   <= '0;
         tx_data_r   <= '0;
         rf_wr_en_r  <= 1'b0;
         rf_rd_en_r  <= 1'b0;
         alu_en_r    <= 1'b0;
         clkg_en_r   <= 1'b0;
         clkdiv_en_r <= 1'b1;
         tx_vld_r    <= 1'b0;
         cmd_err_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         rf_wr_en_r  <= 1'b0;
         rf_rd_en_r  <= 1'b0;
         alu_en_r    <= 1'b0;
         tx_vld_r    <= 1'b0;
         cmd_err_r   <= 1'b0;
         clkdiv_en_r <= 1'b1;
         cnt_r       <= cnt_r + CNT_W'(1);
         case (state_r)
            S_IDLE: begin
               if (UART_RX_VLD) begin
                  cnt_r <= '0;
                  if (UART_RX_DATA == CMD_WR) begin
                     state_r <= S_WR_ADDR;
                     busy_r  <= 1'b1;
                  end else if (UART_RX_DATA == CMD_RD) begin
                     state_r <= S_RD_ADDR;
                     busy_r  <= 1'b1;
                  end else if (UART_RX_DATA == CMD_ALU_OP) begin
                     state_r <= S_OP_A;
                     busy_r  <= 1'b1;
                  end else if (UART_RX_DATA == CMD_ALU_NOP) begin
                     state_r   <= S_ALU_FN;
                     busy_r    <= 1'b1;
                     clkg_en_r <= 1'b1;
                  end else begin
                     cmd_err_r <= 1'b1;
                  end
               end
            end
            S_WR_ADDR: begin
               if (UART_RX_VLD) begin
                  addr_r  <= UART_RX_DATA[ADDR_WIDTH-1:0];
                  state_r <= S_WR_DATA;
                  cnt_r   <= '0;
               end
            end
            S_WR_DATA: begin
               if (UART_RX_VLD) begin
                  rf_wr_en_r <= 1'b1;
                  rf_addr_r  <= addr_r;
                  rf_wdata_r <= UART_RX_DATA;
                  state_r    <= S_IDLE;
                  busy_r     <= 1'b0;
                  cnt_r      <= '0;
               end
            end
            S_RD_ADDR: begin
               if (UART_RX_VLD) begin
                  rf_rd_en_r <= 1'b1;
                  rf_addr_r  <= UART_RX_DATA[ADDR_WIDTH-1:0];
                  state_r    <= S_RD_WAIT;
                  cnt_r      <= '0;
               end
            end
            S_RD_WAIT: begin
               if (RF_RdData_Valid) begin
                  tx_buf_r <= RES_W'(RF_RdData);
                  rem_r    <= REM_W'(1);
                  state_r  <= S_TX;
                  cnt_r    <= '0;
               end
            end
            S_OP_A: begin
               if (UART_RX_VLD) begin
                  rf_wr_en_r <= 1'b1;
                  rf_addr_r  <= ADDR_WIDTH'(OPA_ADDR);
                  rf_wdata_r <= UART_RX_DATA;
                  state_r    <= S_OP_B;
                  cnt_r      <= '0;
               end
            end
            S_OP_B: begin
               if (UART_RX_VLD) begin
                  rf_wr_en_r <= 1'b1;
                  rf_addr_r  <= ADDR_WIDTH'(OPB_ADDR);
                  rf_wdata_r <= UART_RX_DATA;
                  state_r    <= S_ALU_FN;
                  clkg_en_r  <= 1'b1;
                  cnt_r      <= '0;
               end
            end
            S_ALU_FN: begin
               if (UART_RX_VLD) begin
                  alu_fun_r <= UART_RX_DATA[FUN_WIDTH-1:0];
                  alu_en_r  <= 1'b1;
                  state_r   <= S_ALU_WAIT;
                  cnt_r     <= '0;
               end
            end
            S_ALU_WAIT: begin
               if (ALU_OUT_VLD) begin
                  tx_buf_r  <= ALU_OUT;
                  rem_r     <= REM_W'(RES_WORDS);
                  clkg_en_r <= 1'b0;
                  state_r   <= S_TX;
                  cnt_r     <= '0;
               end
            end
            S_TX: begin
               if (!FIFO_FULL) begin
                  tx_vld_r  <= 1'b1;
                  tx_data_r <= tx_buf_r[DATA_WIDTH-1:0];
                  tx_buf_r  <= tx_buf_r >> DATA_WIDTH;
                  rem_r     <= rem_r - REM_W'(1);
                  if (rem_r == REM_W'(1)) begin
                     state_r <= S_IDLE;
                     busy_r  <= 1'b0;
                     cnt_r   <= '0;
                  end
               end
            end
            default: begin
               state_r <= S_IDLE;
               busy_r  <= 1'b0;
               cnt_r   <= '0;
            end
         endcase
         if (tmo_s) begin
            state_r   <= S_IDLE;
            busy_r    <= 1'b0;
            clkg_en_r <= 1'b0;
            cmd_err_r <= 1'b1;
            cnt_r     <= '0;
         end
      end
   end

   assign RF_Address   = rf_addr_r;
   assign RF_WrEn      = rf_wr_en_r;
   assign RF_RdEn      = rf_rd_en_r;
   assign RF_WrData    = rf_wdata_r;
   assign ALU_FUN      = alu_fun_r;
   assign ALU_EN       = alu_en_r;
   assign CLKG_EN      = clkg_en_r;
   assign CLKDIV_EN    = clkdiv_en_r;
   assign UART_TX_DATA = tx_data_r;
   assign UART_TX_VLD  = tx_vld_r;
   assign CMD_ERR      = cmd_err_r;
   assign BUSY         = busy_r;

endmodule

// File: tb/tb_sys_ctrl_gen.sv
// Directed bench for sys_ctrl_gen: a 2-word result build and a 3-word result build.
module tb_sys_ctrl_gen;

   localparam int TMO = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   int          n_total = 0;
   int          n_bad   = 0;

   logic [7:0]  rx_data = 8'h00, rf_rdata = 8'h00;
   logic        rx_vld = 1'b0, fifo_full = 1'b0, rf_vld = 1'b0, alu_vld = 1'b0;
   logic [15:0] alu_out = 16'h0000;
   logic [3:0]  rf_addr;
   logic        rf_wr_en, rf_rd_en, alu_en, clkg_en, clkdiv_en, tx_vld, cmd_err, busy;
   logic [7:0]  rf_wdata, tx_data;
   logic [3:0]  alu_fun;

   logic [7:0]  rx_data3 = 8'h00;
   logic        rx_vld3 = 1'b0, alu_vld3 = 1'b0;
   logic [23:0] alu_out3 = 24'h000000;
   logic [3:0]  rf_addr3, alu_fun3;
   logic        rf_wr_en3, rf_rd_en3, alu_en3, clkg_en3, clkdiv_en3, tx_vld3, cmd_err3, busy3;
   logic [7:0]  rf_wdata3, tx_data3;

   int          cnt_a, cnt_b;

   always #5 clk = ~clk;

   sys_ctrl_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .RES_WORDS(2),
                  .OPA_ADDR(0), .OPB_ADDR(1), .TIMEOUT_CYCLES(TMO)) u_dut (
      .CLK(clk), .RST(rst), .UART_RX_DATA(rx_data), .UART_RX_VLD(rx_vld),
      .FIFO_FULL(fifo_full), .RF_RdData(rf_rdata), .RF_RdData_Valid(rf_vld),
      .ALU_OUT(alu_out), .ALU_OUT_VLD(alu_vld), .RF_Address(rf_addr),
      .RF_WrEn(rf_wr_en), .RF_RdEn(rf_rd_en), .RF_WrData(rf_wdata),
      .ALU_FUN(alu_fun), .ALU_EN(alu_en), .CLKG_EN(clkg_en), .CLKDIV_EN(clkdiv_en),
      .UART_TX_DATA(tx_data), .UART_TX_VLD(tx_vld), .CMD_ERR(cmd_err), .BUSY(busy)
   );

   sys_ctrl_gen #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .RES_WORDS(3),
                  .OPA_ADDR(0), .OPB_ADDR(1), .TIMEOUT_CYCLES(TMO)) u_dut3 (
      .CLK(clk), .RST(rst), .UART_RX_DATA(rx_data3), .UART_RX_VLD(rx_vld3),
      .FIFO_FULL(1'b0), .RF_RdData(8'h00), .RF_RdData_Valid(1'b0),
      .ALU_OUT(alu_out3), .ALU_OUT_VLD(alu_vld3), .RF_Address(rf_addr3),
      .RF_WrEn(rf_wr_en3), .RF_RdEn(rf_rd_en3), .RF_WrData(rf_wdata3),
      .ALU_FUN(alu_fun3), .ALU_EN(alu_en3), .CLKG_EN(clkg_en3), .CLKDIV_EN(clkdiv_en3),
      .UART_TX_DATA(tx_data3), .UART_TX_VLD(tx_vld3), .CMD_ERR(cmd_err3), .BUSY(busy3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_data = b;
      rx_vld  = 1'b1;
      tick();
      rx_vld  = 1'b0;
   endtask

   task automatic send3(input logic [7:0] b);
      rx_data3 = b;
      rx_vld3  = 1'b1;
      tick();
      rx_vld3  = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_clkdiv", clkdiv_en, 1);
      check("rst_strobes", {rf_wr_en, rf_rd_en, alu_en, tx_vld, cmd_err, clkg_en}, 0);
      check("rst_addr", rf_addr, 0);
      rst = 1'b1;
      tick();

      // RF write
      send(8'hAA);
      check("wr_busy", busy, 1);
      send(8'h05);
      check("wr_no_early", rf_wr_en, 0);
      send(8'h3C);
      check("wr_en", rf_wr_en, 1);
      check("wr_addr", rf_addr, 5);
      check("wr_data", rf_wdata, 8'h3C);
      check("wr_busy_done", busy, 0);
      check("wr_no_err", cmd_err, 0);
      tick();
      check("wr_one_cycle", rf_wr_en, 0);
      check("wr_addr_hold", rf_addr, 5);

      // RF read with 10 cycles of FIFO backpressure; a stray RX byte is ignored
      send(8'hBB);
      send(8'h07);
      check("rd_en", rf_rd_en, 1);
      check("rd_addr", rf_addr, 7);
      tick();
      check("rd_one_cycle", rf_rd_en, 0);
      fifo_full = 1'b1;
      rf_rdata  = 8'h5A;
      rf_vld    = 1'b1;
      tick();
      rf_vld = 1'b0;
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < 10; i++) begin
         rx_vld  = (i == 2);
         rx_data = 8'h77;
         tick();
         rx_vld = 1'b0;
         if (tx_vld) cnt_a++;
         if (cmd_err) cnt_b++;
      end
      check("rd_stall_pushes", cnt_a, 0);
      check("rd_stall_no_err", cnt_b, 0);
      check("rd_stall_busy", busy, 1);
      fifo_full = 1'b0;
      tick();
      check("rd_push", tx_vld, 1);
      check("rd_push_data", tx_data, 8'h5A);
      check("rd_idle", busy, 0);
      tick();
      check("rd_single_push", tx_vld, 0);

      // ALU with operands
      send(8'hCC);
      send(8'h12);
      check("opa_wr", {rf_wr_en, rf_addr, rf_wdata}, {1'b1, 4'h0, 8'h12});
      send(8'h34);
      check("opb_wr", {rf_wr_en, rf_addr, rf_wdata}, {1'b1, 4'h1, 8'h34});
      check("opb_clkg", clkg_en, 1);
      send(8'h01);
      check("alu_en", alu_en, 1);
      check("alu_fun", alu_fun, 1);
      check("alu_clkg_fn", clkg_en, 1);
      tick();
      check("alu_en_pulse", alu_en, 0);
      check("alu_clkg_wait", clkg_en, 1);
      alu_out = 16'h0446;
      alu_vld = 1'b1;
      tick();
      alu_vld = 1'b0;
      check("alu_clkg_off", clkg_en, 0);
      check("alu_latch_no_push", tx_vld, 0);
      tick();
      check("alu_push0", {tx_vld, tx_data}, {1'b1, 8'h46});
      tick();
      check("alu_push1", {tx_vld, tx_data}, {1'b1, 8'h04});
      check("alu_idle", busy, 0);
      tick();
      check("alu_push_end", tx_vld, 0);
      check("alu_fun_hold", alu_fun, 1);

      // Bad command byte
      send(8'h77);
      check("bad_cmd_err", cmd_err, 1);
      check("bad_cmd_idle", busy, 0);
      tick();
      check("bad_cmd_pulse", cmd_err, 0);

      // Timeout after AA with no further bytes
      send(8'hAA);
      cnt_a = 0;
      cnt_b = 0;
      for (int i = 0; i < TMO - 1; i++) begin
         tick();
         if (cmd_err) cnt_a++;
         if (rf_wr_en) cnt_b++;
      end
      check("tmo_not_early", cnt_a, 0);
      check("tmo_busy", busy, 1);
      tick();
      check("tmo_err", cmd_err, 1);
      check("tmo_idle", busy, 0);
      check("tmo_no_wr", cnt_b + int'(rf_wr_en), 0);

      // Three-word result build, pushes on consecutive cycles
      send3(8'hDD);
      check("r3_clkg", clkg_en3, 1);
      send3(8'h02);
      check("r3_alu", {alu_en3, alu_fun3}, {1'b1, 4'h2});
      alu_out3 = 24'hABCDEF;
      alu_vld3 = 1'b1;
      tick();
      alu_vld3 = 1'b0;
      tick();
      check("r3_push0", {tx_vld3, tx_data3}, {1'b1, 8'hEF});
      tick();
      check("r3_push1", {tx_vld3, tx_data3}, {1'b1, 8'hCD});
      tick();
      check("r3_push2", {tx_vld3, tx_data3}, {1'b1, 8'hAB});
      check("r3_idle", busy3, 0);
      tick();
      check("r3_push_end", tx_vld3, 0);

      // Reset between the two result pushes
      send(8'hDD);
      send(8'h05);
      check("mid_alu_fun", alu_fun, 5);
      alu_out = 16'hBEEF;
      alu_vld = 1'b1;
      tick();
      alu_vld = 1'b0;
      tick();
      check("mid_push0", {tx_vld, tx_data}, {1'b1, 8'hEF});
      rst = 1'b0;
      #2;
      check("mid_rst_outs", {tx_vld, busy, clkg_en, alu_fun, tx_data}, 0);
      check("mid_rst_clkdiv", clkdiv_en, 1);
      tick();
      tick();
      rst = 1'b1;
      cnt_a = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (tx_vld) cnt_a++;
      end
      check("mid_no_second_push", cnt_a, 0);
      check("mid_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
